// File: rtl/snake_head_stepper_if.sv
// Snake head stepper bus: direction/control inputs and head/status outputs.
// master drives snakeDirection/enable/restart; slave drives head_x/head_y/heading/step/collision/running.
interface snake_head_stepper_if #(
    parameter int GRID_W = 16,
    parameter int GRID_H = 16
);
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);

    logic [1:0]    snakeDirection;
    logic          enable;
    logic          restart;
    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;
    logic [1:0]    heading;
    logic          step;
    logic          collision;
    logic          running;

    modport master (
        output snakeDirection,
        output enable,
        output restart,
        input  head_x,
        input  head_y,
        input  heading,
        input  step,
        input  collision,
        input  running
    );

    modport slave (
        input  snakeDirection,
        input  enable,
        input  restart,
        output head_x,
        output head_y,
        output heading,
        output step,
        output collision,
        output running
    );
endinterface

// File: rtl/snake_head_stepper.sv
// Snake head stepper: moves the head one cell per game tick, drops reversals, detects walls.
// Ports: clk, reset (async active-low), bus (slave: dir/enable/restart in; head/heading/step/collision/running out).
module snake_head_stepper #(
    parameter int GRID_W   = 16,
    parameter int GRID_H   = 16,
    parameter int TICK_DIV = 4,
    parameter int START_X  = 8,
    parameter int START_Y  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    snake_head_stepper_if.slave  bus
);
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int TW = $clog2(TICK_DIV);

    localparam logic [XW-1:0] X_START = XW'(START_X);
    localparam logic [YW-1:0] Y_START = YW'(START_Y);
    localparam logic [XW-1:0] X_LAST  = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(GRID_H - 1);
    localparam logic [TW-1:0] T_LAST  = TW'(TICK_DIV - 1);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DEAD
    } state_e;

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d, x_next;
    logic [YW-1:0] y_q, y_d, y_next;
    logic [1:0]    heading_q, heading_d;
    logic [1:0]    pend_q, pend_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          step_q, step_d;
    logic          wall_hit;
    logic          tick_end;
    logic          reversal;
    logic          running;
    logic          collision;

    // Bound check first, so the +/- below never has to wrap.
    always_comb begin
        x_next   = x_q;
        y_next   = y_q;
        wall_hit = 1'b0;
        unique case (pend_q)
            DIR_UP: begin
                wall_hit = (y_q == '0);
                if (!wall_hit) y_next = y_q - YW'(1);
            end
            DIR_LEFT: begin
                wall_hit = (x_q == '0);
                if (!wall_hit) x_next = x_q - XW'(1);
            end
            DIR_DOWN: begin
                wall_hit = (y_q == Y_LAST);
                if (!wall_hit) y_next = y_q + YW'(1);
            end
            DIR_RIGHT: begin
                wall_hit = (x_q == X_LAST);
                if (!wall_hit) x_next = x_q + XW'(1);
            end
        endcase
    end

    // Restart outranks both enable and the step.
    assign tick_end = (state_q == S_RUN) && bus.enable
                      && !bus.restart && (tick_q == T_LAST);

    // Opposite directions differ only in bit 1.
    assign reversal = ((bus.snakeDirection ^ heading_q) == 2'b10);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.restart) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.enable) state_d = S_RUN;
                end
                S_RUN: begin
                    if (!bus.enable)
                        state_d = S_PAUSE;
                    else if (tick_end && wall_hit)
                        state_d = S_DEAD;
                end
                S_PAUSE: begin
                    if (bus.enable) state_d = S_RUN;
                end
                S_DEAD: begin
                    state_d = S_DEAD;
                end
            endcase
        end
    end

    always_comb begin
        running   = (state_q == S_RUN);
        collision = (state_q == S_DEAD);
    end

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        heading_d = heading_q;
        pend_d    = pend_q;
        tick_d    = tick_q;
        step_d    = 1'b0;
        if (bus.restart) begin
            x_d       = X_START;
            y_d       = Y_START;
            heading_d = DIR_UP;
            pend_d    = DIR_UP;
            tick_d    = '0;
        end else if (state_q != S_DEAD) begin
            if (!reversal) pend_d = bus.snakeDirection;
            if (state_q == S_IDLE) begin
                tick_d = '0;
            end else if (state_q == S_RUN && bus.enable) begin
                if (tick_end) begin
                    tick_d    = '0;
                    heading_d = pend_q;
                    if (!wall_hit) begin
                        x_d    = x_next;
                        y_d    = y_next;
                        step_d = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q       <= X_START;
            y_q       <= Y_START;
            heading_q <= DIR_UP;
            pend_q    <= DIR_UP;
            tick_q    <= '0;
            step_q    <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            heading_q <= heading_d;
            pend_q    <= pend_d;
            tick_q    <= tick_d;
            step_q    <= step_d;
        end
    end

    assign bus.head_x    = x_q;
    assign bus.head_y    = y_q;
    assign bus.heading   = heading_q;
    assign bus.step      = step_q;
    assign bus.collision = collision;
    assign bus.running   = running;
endmodule
